sram_bank_ctrl: RTL

//  Parametrised single-port SRAM bank with byte-lane write enables and a valid/ready

---
 rtl/sram_pkg.sv | 31 +++
 rtl/sram_sp_array.sv | 48 ++++
 rtl/sram_bank_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types, FSM state encodings and the byte-masked merge helper for the SRAM bank.
// Data/byte-enable typedefs are sized for the widest supported bank (512 bits).
package sram_pkg;

   localparam int SRAM_MAX_DATA_W = 512;
   localparam int SRAM_MAX_BYTE_N = SRAM_MAX_DATA_W / 8;

   typedef logic [SRAM_MAX_DATA_W-1:0] sram_data_t;
   typedef logic [SRAM_MAX_BYTE_N-1:0] sram_be_t;
   typedef logic [0:0]                 sram_state_t;

   localparam sram_state_t ST_CLR = 1'b0;
   localparam sram_state_t ST_RUN = 1'b1;

   // Lanes with be[i]=1 take new_word, all others keep old_word.
   function automatic sram_data_t sram_byte_merge(input sram_data_t old_word,
                                                  input sram_data_t new_word,
                                                  input sram_be_t   be);
      sram_data_t merged;
      merged = old_word;
      for (int i = 0; i < SRAM_MAX_BYTE_N; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            merged[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/sram_sp_array.sv
// Behavioural single-port storage array: chip select, write enable, byte lanes,
// registered read data. Contents are never reset; only the read register is.
module sram_sp_array
   import sram_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 128,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int BYTE_N = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [BYTE_N-1:0] be,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [DEPTH];
   sram_data_t        merged_s;
   logic [DATA_W-1:0] write_word_s;

   // Build the post-write word from the current contents and the enabled lanes.
   always_comb begin
      merged_s     = sram_byte_merge(sram_data_t'(mem_r[addr]), sram_data_t'(wdata),
                                     sram_be_t'(be));
      write_word_s = merged_s[DATA_W-1:0];
   end

   // Storage write port.
   always_ff @(posedge clk) begin
      if (cs && we) begin
         mem_r[addr] <= write_word_s;
      end
   end

   // Read data register; holds its value until the next selected read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= {DATA_W{1'b0}};
      end else if (cs && !we) begin
         rdata <= mem_r[addr];
      end
   end

endmodule

// File: rtl/sram_bank_ctrl.sv
// SRAM bank controller: valid/ready request and response handshake, range check,
// and an optional post-reset hardware clear enabled by defining SRAM_INIT_CLR_EN.
module sram_bank_ctrl
   import sram_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 128,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int BYTE_N = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [BYTE_N-1:0] req_byte,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              init_busy
);

   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

   logic              in_range_s;
   logic              accept_s;
   logic              rsp_valid_r;
   logic              rsp_err_r;
   logic              clr_active_s;
   logic [ADDR_W-1:0] clr_addr_s;
   logic              arr_cs_s;
   logic              arr_we_s;
   logic [ADDR_W-1:0] arr_addr_s;
   logic [BYTE_N-1:0] arr_be_s;
   logic [DATA_W-1:0] arr_wdata_s;
   logic [DATA_W-1:0] arr_rdata_s;

`ifdef SRAM_INIT_CLR_EN
   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

   sram_state_t       state_r;
   logic [ADDR_W-1:0] clr_cnt_r;

   // Clear sequencer: one zero write per cycle, then hand over to normal operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_CLR;
         clr_cnt_r <= {ADDR_W{1'b0}};
      end else begin
         case (state_r)
            ST_CLR: begin
               clr_cnt_r <= clr_cnt_r + CNT_ONE;
               if (clr_cnt_r == CLR_LAST) begin
                  state_r <= ST_RUN;
               end
            end
            ST_RUN:  state_r <= ST_RUN;
            default: state_r <= ST_CLR;
         endcase
      end
   end

   assign clr_active_s = (state_r == ST_CLR);
   assign clr_addr_s   = clr_cnt_r;
`else
   assign clr_active_s = 1'b0;
   assign clr_addr_s   = {ADDR_W{1'b0}};
`endif

   assign init_busy = clr_active_s;
   assign req_ready = ~rst & ~clr_active_s & (~rsp_valid_r | rsp_ready);
   assign accept_s  = req_valid & req_ready;

   // Out-of-range addresses never reach the array.
   always_comb begin
      in_range_s = ({1'b0, req_addr} < DEPTH_V);
   end

   // Array port mux: the clear sequencer owns the port while it runs.
   always_comb begin
      if (clr_active_s) begin
         arr_cs_s    = 1'b1;
         arr_we_s    = 1'b1;
         arr_addr_s  = clr_addr_s;
         arr_be_s    = {BYTE_N{1'b1}};
         arr_wdata_s = {DATA_W{1'b0}};
      end else begin
         arr_cs_s    = accept_s & in_range_s;
         arr_we_s    = req_we;
         arr_addr_s  = req_addr;
         arr_be_s    = req_byte;
         arr_wdata_s = req_wdata;
      end
   end

   // Response slot: filled by an accepted read, drained by rsp_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
      end else if (accept_s && !req_we) begin
         rsp_valid_r <= 1'b1;
         rsp_err_r   <= ~in_range_s;
      end else if (rsp_ready) begin
         rsp_valid_r <= 1'b0;
      end
   end

   // Errored reads return zero; the array register keeps its previous word.
   always_comb begin
      if (rsp_err_r) begin
         rsp_rdata = {DATA_W{1'b0}};
      end else begin
         rsp_rdata = arr_rdata_s;
      end
   end

   assign rsp_valid = rsp_valid_r;
   assign rsp_err   = rsp_err_r;

   sram_sp_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .BYTE_N (BYTE_N)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .cs    (arr_cs_s),
      .we    (arr_we_s),
      .addr  (arr_addr_s),
      .be    (arr_be_s),
      .wdata (arr_wdata_s),
      .rdata (arr_rdata_s)
   );

endmodule
